// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Requester identity, also used as the read-return tag.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_tag_e;

    // Start of the I/O window; addresses at or above it never reach dmem.
    localparam logic [31:0] IOBASE_DEFAULT = 32'hFFFFF000;

    // Width of the dmem word index once the byte-offset bits are dropped.
    function automatic int word_idx_bits(input int mem_addr_bits, input int word_bits);
        return mem_addr_bits - word_bits;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_tag_e   last,
    output logic [1:0] gnt
);

    // One-hot grant from the request pair and the last-grant pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == REQ_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU MEM stage (p0) and a
// DMA/debug loader (p1). Default arbitration is round-robin; defining
// DMEM_ARB_CPU_PRIORITY_EN switches to CPU priority with p1 aging.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int              DBITS       = 32,
    parameter int              ABITS       = 32,
    parameter int              MEMADDRBITS = 16,
    parameter int              WORDBITS    = 2,
    parameter logic [ABITS-1:0] IOBASE     = ABITS'(IOBASE_DEFAULT),
    parameter int              MAXWAIT     = 4,
    localparam int             WIDX        = word_idx_bits(MEMADDRBITS, WORDBITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [ABITS-1:0] p0_addr,
    input  logic [DBITS-1:0] p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [DBITS-1:0] p0_rdata,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [ABITS-1:0] p1_addr,
    input  logic [DBITS-1:0] p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [DBITS-1:0] p1_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDX-1:0]  mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);

    logic [1:0]       req_s;
    logic [1:0]       rr_gnt_s;
    logic [1:0]       gnt_s;
    logic             any_gnt_s;
    req_tag_e         win_s;
    logic             we_s;
    logic [ABITS-1:0] addr_s;
    logic [DBITS-1:0] wdata_s;
    logic             io_s;
    logic [DBITS-1:0] ret_data_s;
    logic             p0_ret_s;
    logic             p1_ret_s;

    req_tag_e         last_r;
    logic             pend_r;
    logic             pend_io_r;
    req_tag_e         tag_r;
    logic [DBITS-1:0] p0_hold_r;
    logic [DBITS-1:0] p1_hold_r;

    // Requests are masked while reset is held so no grant can leak out.
    always_comb begin
        if (reset) begin
            req_s = 2'b00;
        end else begin
            req_s = {p1_req, p0_req};
        end
    end

    rr_pick2 u_pick (
        .req  (req_s),
        .last (last_r),
        .gnt  (rr_gnt_s)
    );

`ifdef DMEM_ARB_CPU_PRIORITY_EN
    localparam int WAITW = $clog2(MAXWAIT + 1);
    logic [WAITW-1:0] wait_r;

    // CPU wins contested cycles unless p1 has aged to MAXWAIT.
    always_comb begin
        if (req_s == 2'b11) begin
            if (wait_r >= WAITW'(MAXWAIT)) begin
                gnt_s = 2'b10;
            end else begin
                gnt_s = 2'b01;
            end
        end else begin
            gnt_s = rr_gnt_s;
        end
    end

    // Count cycles p1 spends requesting without being granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_r <= {WAITW{1'b0}};
        end else if (!p1_req || gnt_s[1]) begin
            wait_r <= {WAITW{1'b0}};
        end else if (wait_r < WAITW'(MAXWAIT)) begin
            wait_r <= wait_r + WAITW'(1);
        end else begin
            wait_r <= wait_r;
        end
    end
`else
    // Pure round-robin: the picker decides alone.
    always_comb begin
        gnt_s = rr_gnt_s;
    end
`endif

    // Steer the winner onto the memory port; I/O space never strobes dmem.
    always_comb begin
        any_gnt_s = |gnt_s;
        if (gnt_s[1]) begin
            win_s   = REQ_DMA;
            we_s    = p1_we;
            addr_s  = p1_addr;
            wdata_s = p1_wdata;
        end else begin
            win_s   = REQ_CPU;
            we_s    = p0_we;
            addr_s  = p0_addr;
            wdata_s = p0_wdata;
        end
        io_s   = (addr_s >= IOBASE);
        p0_gnt = gnt_s[0];
        p1_gnt = gnt_s[1];
        mem_en = any_gnt_s & ~io_s;
        mem_we = any_gnt_s & ~io_s & we_s;
        if (any_gnt_s) begin
            mem_addr  = addr_s[MEMADDRBITS-1:WORDBITS];
            mem_wdata = wdata_s;
        end else begin
            mem_addr  = {WIDX{1'b0}};
            mem_wdata = {DBITS{1'b0}};
        end
    end

    // Route returning read data to the tagged port; the other port holds.
    always_comb begin
        if (pend_io_r) begin
            ret_data_s = {DBITS{1'b0}};
        end else begin
            ret_data_s = mem_rdata;
        end
        p0_ret_s  = pend_r & (tag_r == REQ_CPU);
        p1_ret_s  = pend_r & (tag_r == REQ_DMA);
        p0_rvalid = p0_ret_s;
        p1_rvalid = p1_ret_s;
        p0_rdata  = p0_ret_s ? ret_data_s : p0_hold_r;
        p1_rdata  = p1_ret_s ? ret_data_s : p1_hold_r;
    end

    // Last-grant pointer, read-return tracking and per-port data hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r    <= REQ_DMA;
            pend_r    <= 1'b0;
            pend_io_r <= 1'b0;
            tag_r     <= REQ_CPU;
            p0_hold_r <= {DBITS{1'b0}};
            p1_hold_r <= {DBITS{1'b0}};
        end else begin
            pend_r <= any_gnt_s & ~we_s;
            if (any_gnt_s) begin
                last_r    <= win_s;
                tag_r     <= win_s;
                pend_io_r <= io_s;
            end
            if (p0_ret_s) begin
                p0_hold_r <= ret_data_s;
            end
            if (p1_ret_s) begin
                p1_hold_r <= ret_data_s;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are checked on the
// falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, 10ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // Directed sequence.
    initial begin
        logic exp_p1;
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        mem_rdata = 32'h0;

        // Reset holds every output low even with a request present.
        next_cycle();
        p0_req = 1'b1; p0_addr = 32'h0000_0104;
        settle();
        chk("rst_p0_gnt", {31'b0, p0_gnt}, 32'h0);
        chk("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'h0);
        chk("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_p1_rdata", p1_rdata, 32'h0);

        // Lone p0 read of 0x104.
        next_cycle();
        reset = 1'b0;
        settle();
        chk("rd_p0_gnt", {31'b0, p0_gnt}, 32'h1);
        chk("rd_p1_gnt", {31'b0, p1_gnt}, 32'h0);
        chk("rd_mem_en", {31'b0, mem_en}, 32'h1);
        chk("rd_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rd_mem_addr", {18'b0, mem_addr}, 32'h0000_0041);

        next_cycle();
        p0_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("rd_p0_rvalid", {31'b0, p0_rvalid}, 32'h1);
        chk("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        chk("rd_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
        chk("rd_idle_mem_en", {31'b0, mem_en}, 32'h0);

        next_cycle();
        mem_rdata = 32'h5555_AAAA;
        settle();
        chk("rd_p0_rvalid_pulse", {31'b0, p0_rvalid}, 32'h0);
        chk("rd_p0_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

        // Reset pulse so the pointer starts at p1 again.
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;

        // Both ports write every cycle.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0000_0010; p0_wdata = 32'hA0 + i;
            p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0020; p1_wdata = 32'hB0 + i;
            settle();
`ifdef DMEM_ARB_CPU_PRIORITY_EN
            exp_p1 = (i == 4);
`else
            exp_p1 = (i % 2 == 1);
`endif
            chk($sformatf("wr%0d_p0_gnt", i), {31'b0, p0_gnt}, {31'b0, ~exp_p1});
            chk($sformatf("wr%0d_p1_gnt", i), {31'b0, p1_gnt}, {31'b0, exp_p1});
            chk($sformatf("wr%0d_mem_we", i), {31'b0, mem_we}, 32'h1);
            chk($sformatf("wr%0d_mem_wdata", i), mem_wdata, exp_p1 ? 32'hB0 + i : 32'hA0 + i);
        end

        // Idle after writes: no strobes, no read return.
        next_cycle();
        p0_req = 1'b0; p0_we = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
        settle();
        chk("idle_mem_en", {31'b0, mem_en}, 32'h0);
        chk("idle_mem_we", {31'b0, mem_we}, 32'h0);
        chk("idle_p0_rvalid", {31'b0, p0_rvalid}, 32'h0);
        chk("idle_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);

        // Back-to-back reads: p0 at 0x100 then p1 at 0x200.
        next_cycle();
        p0_req = 1'b1; p0_addr = 32'h0000_0100;
        settle();
        chk("b2b_p0_gnt", {31'b0, p0_gnt}, 32'h1);
        chk("b2b_p0_addr", {18'b0, mem_addr}, 32'h0000_0040);

        next_cycle();
        p0_req = 1'b0; p1_req = 1'b1; p1_addr = 32'h0000_0200; mem_rdata = 32'h1111_1111;
        settle();
        chk("b2b_p1_gnt", {31'b0, p1_gnt}, 32'h1);
        chk("b2b_p1_addr", {18'b0, mem_addr}, 32'h0000_0080);
        chk("b2b_p0_rvalid", {31'b0, p0_rvalid}, 32'h1);
        chk("b2b_p0_rdata", p0_rdata, 32'h1111_1111);
        chk("b2b_p1_rvalid_early", {31'b0, p1_rvalid}, 32'h0);

        next_cycle();
        p1_req = 1'b0; mem_rdata = 32'h2222_2222;
        settle();
        chk("b2b_p1_rvalid", {31'b0, p1_rvalid}, 32'h1);
        chk("b2b_p1_rdata", p1_rdata, 32'h2222_2222);
        chk("b2b_p0_rvalid_off", {31'b0, p0_rvalid}, 32'h0);
        chk("b2b_p0_rdata_hold", p0_rdata, 32'h1111_1111);

        // I/O space: write dropped, read returns zero.
        next_cycle();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'hFFFF_F000; p0_wdata = 32'h0012_3456;
        settle();
        chk("io_wr_gnt", {31'b0, p0_gnt}, 32'h1);
        chk("io_wr_mem_en", {31'b0, mem_en}, 32'h0);
        chk("io_wr_mem_we", {31'b0, mem_we}, 32'h0);

        next_cycle();
        p0_req = 1'b0; p0_we = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'hFFFF_F080;
        settle();
        chk("io_rd_gnt", {31'b0, p1_gnt}, 32'h1);
        chk("io_rd_mem_en", {31'b0, mem_en}, 32'h0);
        chk("io_wr_no_rvalid", {31'b0, p0_rvalid}, 32'h0);

        next_cycle();
        p1_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
        settle();
        chk("io_rd_rvalid", {31'b0, p1_rvalid}, 32'h1);
        chk("io_rd_rdata", p1_rdata, 32'h0);

        // Reset right after a p1 read grant discards the return.
        next_cycle();
        p1_req = 1'b1; p1_addr = 32'h0000_0300;
        settle();
        chk("rr_p1_gnt", {31'b0, p1_gnt}, 32'h1);
        chk("rr_mem_addr", {18'b0, mem_addr}, 32'h0000_00C0);

        next_cycle();
        p1_req = 1'b0; reset = 1'b1; mem_rdata = 32'h7777_7777;
        settle();
        chk("rr_p1_rvalid_rst", {31'b0, p1_rvalid}, 32'h0);
        chk("rr_p1_rdata_rst", p1_rdata, 32'h0);
        chk("rr_p0_rdata_rst", p0_rdata, 32'h0);
        chk("rr_mem_en_rst", {31'b0, mem_en}, 32'h0);

        for (int i = 0; i < 2; i++) begin
            next_cycle();
            reset = 1'b0;
            settle();
            chk($sformatf("rr_p1_rvalid_after%0d", i), {31'b0, p1_rvalid}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
